// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage. Holds the PC, issues one fetch at a time to
//   instruction memory over a request/response handshake, and presents the
//   returned instruction with its PC to decode. A taken redirect from
//   execute reloads the PC and discards any in-flight or held instruction.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   imem_req_valid/ready        fetch request handshake
//   imem_addr                   fetch address (current PC)
//   imem_rsp_valid/data         instruction response, one per accepted request
//   redirect_valid/pc           taken branch/jump target from execute
//   dec_valid/ready             handshake towards decode
//   dec_instr, dec_pc           held instruction and its PC
//   dec_pc_plus4                dec_pc + 4 (wraps modulo 2^ADDR_WIDTH)
//
// States
//   state   | meaning
//   S_REQ   | request instruction at pc
//   S_WAIT  | request accepted, waiting for its response
//   S_HOLD  | instruction presented to decode until handshake
//   S_DRAIN | waiting for the response of a squashed request

module fetch_stage #(
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [ADDR_WIDTH-1:0] dec_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_dec_valid;
  logic [DATA_WIDTH-1:0] r_dec_instr;
  logic [ADDR_WIDTH-1:0] r_dec_pc;
  logic [ADDR_WIDTH-1:0] r_dec_pc_plus4;

  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic                  w_rsp_take;
  logic                  w_req_fire;

  // Targets are forced to word alignment; low bits of redirect_pc are ignored.
  assign w_redirect_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_pc_plus4    = r_pc + ADDR_WIDTH'(4);
  assign w_req_fire    = imem_req_valid && imem_req_ready;
  // A response arriving in the same cycle as a redirect is discarded.
  assign w_rsp_take    = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid || dec_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Output logic: request is combinational from state, pc and redirect.
  // rst_n gates the request so nothing is offered while reset is held.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst_n && (r_state == S_REQ) && !redirect_valid) begin
      imem_req_valid = 1'b1;
    end
  end

  assign imem_addr = r_pc;

  // PC and decode-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      r_dec_valid    <= 1'b0;
      r_dec_instr    <= '0;
      r_dec_pc       <= '0;
      r_dec_pc_plus4 <= ADDR_WIDTH'(4);
    end else if (redirect_valid) begin
      r_pc        <= w_redirect_pc;
      r_dec_valid <= 1'b0;
    end else if (w_rsp_take) begin
      r_dec_valid    <= 1'b1;
      r_dec_instr    <= imem_rsp_data;
      r_dec_pc       <= r_pc;
      r_dec_pc_plus4 <= w_pc_plus4;
      r_pc           <= w_pc_plus4;
    end else if ((r_state == S_HOLD) && dec_ready) begin
      r_dec_valid <= 1'b0;
    end
  end

  assign dec_valid    = r_dec_valid;
  assign dec_instr    = r_dec_instr;
  assign dec_pc       = r_dec_pc;
  assign dec_pc_plus4 = r_dec_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;

  // second instance: RESET_PC at the top of the address space, driven directly
  logic        req_valid2, ready2, rsp_valid2, dec_valid2, dec_ready2;
  logic        redirect2;
  logic [31:0] addr2, rsp_data2, redirect_pc2, dec_instr2, dec_pc2, dec_pc_plus4_2;

  fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4)
  );

  fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid2), .imem_req_ready(ready2),
    .imem_addr(addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
    .dec_valid(dec_valid2), .dec_ready(dec_ready2),
    .dec_instr(dec_instr2), .dec_pc(dec_pc2), .dec_pc_plus4(dec_pc_plus4_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cnt  = 0;
  int mem_dly = 0;

  logic [31:0] exp_pc[$];
  logic [31:0] exp_instr[$];
  logic [31:0] issued[$];
  int          hs_cyc[$];

  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  logic [31:0] exp_issue [12] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
                                  32'h018, 32'h100, 32'h104, 32'h200, 32'h204, 32'h300};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_instr.push_back(mem_word(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_cnt < n && k < 60) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("hs_count", 32'(hs_cnt), 32'(n));
  endtask

  task automatic wait_issue(input int n);
    int k = 0;
    while (issued.size() < n && k < 60) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("issue_count", 32'(issued.size()), 32'(n));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: samples the request at the falling edge (inputs change only
  // just after the rising edge), answers mem_dly cycles after the acceptance.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mem_busy       = 1'b0;
      imem_rsp_valid = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
          mem_busy       = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        issued.push_back(imem_addr);
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = mem_dly;
      end
    end
  end

  // Decode-side monitor: each handshake pops and checks the scoreboard.
  initial forever begin
    logic [31:0] e_pc, e_in;
    @(negedge clk);
    if (rst_n && dec_valid && dec_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_pc.size() == 0) begin
        chk("sb_underflow", 32'(exp_pc.size()), 32'd1);
      end else begin
        e_pc = exp_pc.pop_front();
        e_in = exp_instr.pop_front();
        chk("dec_pc", dec_pc, e_pc);
        chk("dec_instr", dec_instr, e_in);
        chk("dec_pc_plus4", dec_pc_plus4, e_pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    ready2 = 1'b0; rsp_valid2 = 1'b0; rsp_data2 = '0; dec_ready2 = 1'b0;
    redirect2 = 1'b0; redirect_pc2 = '0;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_pc_plus4", dec_pc_plus4, 32'd4);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst2_addr", addr2, 32'hFFFF_FFFC);

    // back-to-back fetch with zero-wait memory
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    tick(); rst_n = 1'b1;
    wait_hs(3);
    imem_req_ready = 1'b0;
    chk("gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    chk("gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

    // decode stall for 5 cycles in HOLD
    push_exp(32'hC); push_exp(32'h10);
    tick(); dec_ready = 1'b0; imem_req_ready = 1'b1;
    k = 0;
    while (!dec_valid && k < 20) begin @(negedge clk); #2; k++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_dec_valid", 32'(dec_valid), 32'd1);
      chk("stall_dec_pc", dec_pc, 32'hC);
      chk("stall_dec_instr", dec_instr, mem_word(32'hC));
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      if (i < 4) begin @(negedge clk); #2; end
    end
    chk("stall_issued", 32'(issued.size()), 32'd4);
    tick(); dec_ready = 1'b1;
    @(negedge clk); #2;
    @(negedge clk); #2;
    chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
    chk("resume_addr", imem_addr, 32'h10);
    wait_hs(5);
    imem_req_ready = 1'b0;

    // request backpressure then slow response
    push_exp(32'h14);
    tick(); mem_dly = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_addr", imem_addr, 32'h14);
    end
    tick(); imem_req_ready = 1'b1;
    wait_hs(6);
    imem_req_ready = 1'b0;
    chk("bp_issued", 32'(issued.size()), 32'd6);

    // redirect in WAIT without response: stale response drained
    push_exp(32'h100);
    mem_dly = 1;
    tick(); imem_req_ready = 1'b1;
    wait_issue(7);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick(); redirect_valid = 1'b0;
    @(negedge clk); #2;
    chk("drain_no_req", 32'(imem_req_valid), 32'd0);
    wait_hs(7);
    imem_req_ready = 1'b0;
    mem_dly = 0;

    // redirect in WAIT coinciding with the response
    push_exp(32'h200);
    tick(); imem_req_ready = 1'b1;
    wait_issue(9);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick(); redirect_valid = 1'b0;
    wait_hs(8);
    imem_req_ready = 1'b0;

    // redirect in HOLD together with dec_ready: transfer still completes
    push_exp(32'h204); push_exp(32'h300);
    tick(); imem_req_ready = 1'b1;
    wait_issue(11);
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0301;
    tick(); redirect_valid = 1'b0;
    wait_hs(10);
    imem_req_ready = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("no_extra_hs", 32'(hs_cnt), 32'd10);
    chk("sb_left", 32'(exp_pc.size()), 32'd0);
    chk("issued_total", 32'(issued.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < issued.size()) chk($sformatf("issue%0d", i), issued[i], exp_issue[i]);
    end

    // wrap-around at top of address space and async reset mid-WAIT
    @(negedge clk); #2;
    chk("wrap_req_valid", 32'(req_valid2), 32'd1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    tick(); ready2 = 1'b1;
    tick(); ready2 = 1'b0; rsp_valid2 = 1'b1; rsp_data2 = 32'h0010_0073;
    tick(); rsp_valid2 = 1'b0;
    @(negedge clk); #2;
    chk("wrap_dec_valid", 32'(dec_valid2), 32'd1);
    chk("wrap_dec_pc", dec_pc2, 32'hFFFF_FFFC);
    chk("wrap_dec_pc_plus4", dec_pc_plus4_2, 32'h0);
    chk("wrap_dec_instr", dec_instr2, 32'h0010_0073);
    tick(); dec_ready2 = 1'b1;
    tick(); dec_ready2 = 1'b0;
    @(negedge clk); #2;
    chk("wrap_next_addr", addr2, 32'h0);
    chk("wrap_next_valid", 32'(req_valid2), 32'd1);
    tick(); ready2 = 1'b1;
    tick(); ready2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(req_valid2), 32'd0);
    chk("arst_dec_valid", 32'(dec_valid2), 32'd0);
    chk("arst_dec_instr", dec_instr2, 32'd0);
    chk("arst_dec_pc", dec_pc2, 32'd0);
    chk("arst_dec_pc_plus4", dec_pc_plus4_2, 32'd4);
    chk("arst_addr", addr2, 32'hFFFF_FFFC);
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_valid", 32'(req_valid2), 32'd1);
    chk("post_rst_addr", addr2, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
